bus_dma: RTL and testbench
==========================

# bus_dma

Word-granular DMA engine that acts as a bus initiator on the on-chip word bus (30-bit word address, 32-bit data, 4-bit byte write mask; a cycle with all-zero mask is a read whose data returns on the next cycle). It copies a block of words from a source to a destination, or fills a block with a constant. It sits beside `Cpu` as a second initiator in front of `Ram`. It also serves as the preload/clear engine in the test harness.

## Interface
- `LEN_W`, default 16: width of the transfer length in words.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a transfer; sampled only in Idle.
- `mode`  in  1  0 = copy, 1 = fill; sampled with `start`.
- `src`  in  30  source word address (copy); sampled with `start`.
- `dst`  in  30  destination word address; sampled with `start`.
- `len`  in  LEN_W  number of words; sampled with `start`.
- `fill_data`  in  32  fill word (fill mode); sampled with `start`.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `bus_addr`  out  30  word address driven to the responder.
- `bus_data_r`  in  32  read data, valid the cycle after a read cycle.
- `bus_data_w`  out  32  write data.
- `bus_mask_w`  out  4  byte write enables; 0 = read cycle.

## Operation
- Registers: state, `src_cur`, `dst_cur`, `remaining` (LEN_W), `fill_q` (32), `done`.
- States: Idle, Read, Write, Fill.
- Idle: `bus_addr` = 0, `bus_mask_w` = 0, `bus_data_w` = 0, `busy` = 0.
  - On `start`, latch all inputs.
  - If `len` = 0: stay in Idle and pulse `done` next cycle.
  - Otherwise go to Read if `mode` = 0, or Fill if `mode` = 1.
- Read: drive `bus_addr` = `src_cur`, `bus_mask_w` = 0. Increment `src_cur`. Go to Write.
- Write: drive `bus_addr` = `dst_cur`, `bus_mask_w` = 4'hF, `bus_data_w` = `bus_data_r` (combinational pass-through of the responder's registered read data).
  - Increment `dst_cur` and decrement `remaining`.
  - If `remaining` = 1: go to Idle and set `done`. Otherwise go to Read.
- Fill: drive `bus_addr` = `dst_cur`, `bus_mask_w` = 4'hF, `bus_data_w` = `fill_q`.
  - Increment `dst_cur` and decrement `remaining`.
  - If `remaining` = 1: go to Idle and set `done`.
- `busy` = (state != Idle), decoded combinationally.
- `done` is registered. It is high for exactly one cycle, in the first Idle cycle after completion.
- Address arithmetic is modulo 2^30: 30'h3FFFFFFF + 1 wraps to 0.
- Copy is strictly forward, word by word. With overlapping ranges where `dst` > `src`, already-written words are re-read. The result is the defined replication pattern; no overlap correction is applied.
- `start` while `busy` is ignored; inputs are not re-latched.
- `start` in the same cycle that `done` is high is accepted normally.

## Timing
- Reset (asynchronous): state = Idle, `done` = 0, `busy` = 0, `bus_addr` = 0, `bus_mask_w` = 0, `bus_data_w` = 0.
- Reset mid-transfer aborts immediately. Words already written stay written; no `done` pulse is produced.
- Start → bus activity latency is 1 cycle: `start` sampled at edge E0, first Read/Fill cycle is E0..E1.
- Copy of N words: 2N bus cycles, alternating R, W. `done` is high in cycle 2N+1 after the `start` edge.
- Fill of N words: N write cycles. `done` is high in cycle N+1.
- `len` = 0: no bus write occurs. `done` is high in the cycle after `start`.
- `busy` falls in the same cycle `done` rises.
- The responder never stalls, and the engine issues no wait cycles.

## Test plan
- Copy, `len` = 4, `src` = 0x100, `dst` = 0x200, Ram preloaded with 0x11111111..0x44444444 → 8 bus cycles R,W,R,W,R,W,R,W; `done` 9 cycles after `start`; Ram[0x200..0x203] match; Ram[0x204] unchanged.
- Fill, `len` = 3, `dst` = 0x40, `fill_data` = 0xDEADBEEF → 3 consecutive cycles with mask 4'hF; Ram[0x40..0x42] = 0xDEADBEEF; `done` at cycle 4.
- `len` = 0, either mode → mask stays 0; `busy` never high; `done` pulses once, 1 cycle after `start`.
- `start` pulsed again mid-copy with different `src`/`len` → ignored; original transfer completes with unchanged count and addresses.
- Reset asserted after the 2nd write of a 5-word copy → outputs 0 immediately; 2 words written, 3 untouched; no `done`; a new `start` afterwards works normally.
- Fill, `dst` = 0x3FFFFFFE, `len` = 4 → `bus_addr` sequence 0x3FFFFFFE, 0x3FFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/bus_dma.sv
// bus_dma: word-granular DMA initiator for the on-chip word bus.
// Copies a block of words from src to dst (alternating read/write cycles)
// or fills a block at dst with a constant word.
//
// Ports:
//   clock, reset      - system clock, asynchronous active-high reset
//   start, mode       - transfer request (Idle only); 0 = copy, 1 = fill
//   src, dst, len     - source/destination word addresses, length in words
//   fill_data         - constant word for fill mode
//   busy, done        - transfer in progress; one-cycle completion pulse
//   bus_addr          - word address driven to the responder
//   bus_data_r        - read data, valid the cycle after a read cycle
//   bus_data_w        - write data
//   bus_mask_w        - byte write enables (0 = read cycle)
module bus_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [29:0]      src,
  input  logic [29:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic [29:0]      bus_addr,
  input  logic [31:0]      bus_data_r,
  output logic [31:0]      bus_data_w,
  output logic [3:0]       bus_mask_w
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_FILL  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [29:0]      src_q, src_d;
  logic [29:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      fill_q, fill_d;
  logic             done_q, done_d;
  logic [29:0]      addr_q, addr_d;
  logic [3:0]       mask_q, mask_d;

  // Next-state, address/count update and next-cycle bus address/mask.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src;
          dst_d  = dst;
          rem_d  = len;
          fill_d = fill_data;
          if (len == {LEN_W{1'b0}}) begin
            done_d = 1'b1;
          end else if (mode) begin
            state_d = S_FILL;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        src_d   = src_q + 30'd1;
        state_d = S_WRITE;
      end
      S_WRITE, S_FILL: begin
        dst_d = dst_q + 30'd1;
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (state_q == S_WRITE) begin
          state_d = S_READ;
        end else begin
          state_d = S_FILL;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus address/mask are registered: compute what the next cycle drives.
    // src_d/dst_d already hold the address the next state will present.
    addr_d = 30'h0;
    mask_d = 4'h0;
    case (state_d)
      S_READ: begin
        addr_d = src_d;
        mask_d = 4'h0;
      end
      S_WRITE, S_FILL: begin
        addr_d = dst_d;
        mask_d = 4'hF;
      end
      default: begin
        addr_d = 30'h0;
        mask_d = 4'h0;
      end
    endcase
  end

  // All engine state; reset aborts any transfer without a done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= 30'h0;
      dst_q   <= 30'h0;
      rem_q   <= {LEN_W{1'b0}};
      fill_q  <= 32'h0;
      done_q  <= 1'b0;
      addr_q  <= 30'h0;
      mask_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

  // Write data: read data flows straight through in Write, since the
  // responder's registered read data arrives in exactly that cycle.
  always_comb begin
    if (state_q == S_WRITE) begin
      bus_data_w = bus_data_r;
    end else if (state_q == S_FILL) begin
      bus_data_w = fill_q;
    end else begin
      bus_data_w = 32'h0;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign bus_addr   = addr_q;
  assign bus_mask_w = mask_q;

endmodule

// File: tb/tb_bus_dma.sv
// Self-checking bench for bus_dma: a word RAM responder model, a bus
// scoreboard comparing every active bus cycle against expected entries,
// and one task per scenario checking done timing and memory contents.
module tb_bus_dma;

  localparam int LEN_W = 16;

  logic             clock;
  logic             reset;
  logic             start;
  logic             mode;
  logic [29:0]      src;
  logic [29:0]      dst;
  logic [LEN_W-1:0] len;
  logic [31:0]      fill_data;
  logic             busy;
  logic             done;
  logic [29:0]      bus_addr;
  logic [31:0]      bus_data_r;
  logic [31:0]      bus_data_w;
  logic [3:0]       bus_mask_w;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } bus_t;

  bus_t        exp_q[$];
  logic [31:0] ram[logic [29:0]];
  logic [31:0] exp_mem[logic [29:0]];

  bus_dma #(.LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src(src), .dst(dst), .len(len), .fill_data(fill_data),
    .busy(busy), .done(done), .bus_addr(bus_addr),
    .bus_data_r(bus_data_r), .bus_data_w(bus_data_w), .bus_mask_w(bus_mask_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ram_rd(logic [29:0] a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_rd(logic [29:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
  endfunction

  // RAM responder: registered read data, byte-masked writes
  always @(posedge clock) begin
    logic [31:0] w;
    if (bus_mask_w == 4'h0) begin
      bus_data_r <= ram_rd(bus_addr);
    end else begin
      w = ram_rd(bus_addr);
      for (int b = 0; b < 4; b++) if (bus_mask_w[b]) w[8*b +: 8] = bus_data_w[8*b +: 8];
      ram[bus_addr] = w;
    end
  end

  // Scoreboard: every cycle with bus activity must match the next expected entry
  always @(negedge clock) begin
    bus_t e;
    if (!reset && (busy || bus_mask_w != 4'h0 || bus_addr != 30'h0 || bus_data_w != 32'h0)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL bus_unexpected: got addr=%h mask=%h data=%h busy=%b, required idle bus", bus_addr, bus_mask_w, bus_data_w, busy);
      end else begin
        e = exp_q.pop_front();
        if (bus_addr !== e.addr || bus_mask_w !== e.mask || (e.mask != 4'h0 && bus_data_w !== e.data)) begin
          n_fail++;
          $display("FAIL bus_cycle: got addr=%h mask=%h data=%h, required addr=%h mask=%h data=%h", bus_addr, bus_mask_w, bus_data_w, e.addr, e.mask, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic preload(input logic [29:0] a, input logic [31:0] v);
    ram[a] = v;
    exp_mem[a] = v;
  endtask

  task automatic push_copy(input logic [29:0] s, input logic [29:0] d, input int n);
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      v = exp_rd(s + 30'(i));
      exp_q.push_back('{addr: s + 30'(i), mask: 4'h0, data: 32'h0});
      exp_mem[d + 30'(i)] = v;
      exp_q.push_back('{addr: d + 30'(i), mask: 4'hF, data: v});
    end
  endtask

  task automatic push_fill(input logic [29:0] d, input int n, input logic [31:0] f);
    for (int i = 0; i < n; i++) begin
      exp_mem[d + 30'(i)] = f;
      exp_q.push_back('{addr: d + 30'(i), mask: 4'hF, data: f});
    end
  endtask

  // Drives one start cycle; returns at the negedge of cycle 1 after the start edge
  task automatic launch(input logic m, input logic [29:0] s, input logic [29:0] d,
                        input logic [LEN_W-1:0] l, input logic [31:0] f);
    start = 1'b1; mode = m; src = s; dst = d; len = l; fill_data = f;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Bounded wait for done; c = cycle index of done after the start edge, -1 on timeout
  task automatic wait_done(input int c0, input int bound, output int c);
    c = c0;
    while (done !== 1'b1 && c < bound) begin
      @(negedge clock);
      c++;
    end
    if (done !== 1'b1) c = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; mode = 1'b0; src = 30'h0; dst = 30'h0;
    len = '0; fill_data = 32'h0;
    repeat (2) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    n_checks++; if (bus_addr !== 30'h0) begin n_fail++; $display("FAIL reset_addr: got %h, required 0", bus_addr); end
    n_checks++; if (bus_mask_w !== 4'h0) begin n_fail++; $display("FAIL reset_mask: got %h, required 0", bus_mask_w); end
    n_checks++; if (bus_data_w !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h, required 0", bus_data_w); end
    #2 reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_copy;
    int c;
    for (int i = 0; i < 4; i++) preload(30'h100 + 30'(i), 32'h11111111 * 32'(i + 1));
    for (int i = 0; i < 5; i++) preload(30'h200 + 30'(i), 32'hA5A50000 + 32'(i));
    push_copy(30'h100, 30'h200, 4);
    launch(1'b0, 30'h100, 30'h200, 16'd4, 32'h0);
    wait_done(1, 40, c);
    n_checks++; if (c != 9) begin n_fail++; $display("FAIL copy_done_cycle: got %0d, required 9", c); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL copy_busy_at_done: got %b, required 0", busy); end
    @(negedge clock);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL copy_done_width: got %b, required 0", done); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL copy_missing_cycles: got %0d left, required 0", exp_q.size()); exp_q.delete(); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ram_rd(30'h200 + 30'(i)) !== 32'h11111111 * 32'(i + 1)) begin
        n_fail++; $display("FAIL copy_ram[%0d]: got %h, required %h", i, ram_rd(30'h200 + 30'(i)), 32'h11111111 * 32'(i + 1));
      end
    end
    n_checks++; if (ram_rd(30'h204) !== 32'hA5A50004) begin n_fail++; $display("FAIL copy_ram_beyond: got %h, required a5a50004", ram_rd(30'h204)); end
  endtask

  task automatic test_fill;
    int c;
    push_fill(30'h40, 3, 32'hDEADBEEF);
    launch(1'b1, 30'h0, 30'h40, 16'd3, 32'hDEADBEEF);
    wait_done(1, 20, c);
    n_checks++; if (c != 4) begin n_fail++; $display("FAIL fill_done_cycle: got %0d, required 4", c); end
    @(negedge clock);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fill_missing_cycles: got %0d left, required 0", exp_q.size()); exp_q.delete(); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ram_rd(30'h40 + 30'(i)) !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL fill_ram[%0d]: got %h, required deadbeef", i, ram_rd(30'h40 + 30'(i)));
      end
    end
  endtask

  task automatic test_len_zero;
    preload(30'h50, 32'h5A5A5A5A);
    for (int m = 0; m < 2; m++) begin
      launch(m[0], 30'h0, 30'h50, 16'd0, 32'h01234567);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL len0_done m=%0d: got %b, required 1", m, done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy m=%0d: got %b, required 0", m, busy); end
      @(negedge clock);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL len0_done_width m=%0d: got %b, required 0", m, done); end
    end
    n_checks++; if (ram_rd(30'h50) !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL len0_ram: got %h, required 5a5a5a5a", ram_rd(30'h50)); end
  endtask

  task automatic test_back_to_back;
    int c;
    launch(1'b1, 30'h0, 30'h60, 16'd0, 32'h0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b, required 1", done); end
    push_fill(30'h60, 2, 32'h12345678);
    launch(1'b1, 30'h0, 30'h60, 16'd2, 32'h12345678);
    wait_done(1, 20, c);
    n_checks++; if (c != 3) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d, required 3", c); end
    @(negedge clock);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_cycles: got %0d left, required 0", exp_q.size()); exp_q.delete(); end
    n_checks++; if (ram_rd(30'h61) !== 32'h12345678) begin n_fail++; $display("FAIL b2b_ram: got %h, required 12345678", ram_rd(30'h61)); end
  endtask

  // Overlapping forward copy (dst = src+2) with a second start mid-transfer
  task automatic test_start_ignored;
    int c;
    preload(30'h300, 32'hAAAA0000);
    preload(30'h301, 32'hBBBB1111);
    for (int i = 2; i < 6; i++) preload(30'h300 + 30'(i), 32'hEEEE0000 + 32'(i));
    preload(30'h700, 32'h77777777);
    push_copy(30'h300, 30'h302, 4);
    launch(1'b0, 30'h300, 30'h302, 16'd4, 32'h0);
    @(negedge clock);
    start = 1'b1; mode = 1'b1; src = 30'h500; dst = 30'h700; len = 16'd9; fill_data = 32'hFFFFFFFF;
    @(negedge clock);
    start = 1'b0;
    wait_done(3, 60, c);
    n_checks++; if (c != 9) begin n_fail++; $display("FAIL ign_done_cycle: got %0d, required 9", c); end
    @(negedge clock);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ign_missing_cycles: got %0d left, required 0", exp_q.size()); exp_q.delete(); end
    n_checks++; if (ram_rd(30'h304) !== 32'hAAAA0000) begin n_fail++; $display("FAIL ign_replicate0: got %h, required aaaa0000", ram_rd(30'h304)); end
    n_checks++; if (ram_rd(30'h305) !== 32'hBBBB1111) begin n_fail++; $display("FAIL ign_replicate1: got %h, required bbbb1111", ram_rd(30'h305)); end
    n_checks++; if (ram_rd(30'h700) !== 32'h77777777) begin n_fail++; $display("FAIL ign_second_dst: got %h, required 77777777", ram_rd(30'h700)); end
  endtask

  task automatic test_reset_abort;
    int c;
    bit saw_done;
    for (int i = 0; i < 5; i++) begin
      preload(30'h400 + 30'(i), 32'hC0DE0000 + 32'(i));
      preload(30'h410 + 30'(i), 32'hFFFF0000 + 32'(i));
    end
    push_copy(30'h400, 30'h410, 2);
    exp_q.push_back('{addr: 30'h402, mask: 4'h0, data: 32'h0});
    launch(1'b0, 30'h400, 30'h410, 16'd5, 32'h0);
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", busy); end
    n_checks++; if (bus_addr !== 30'h0 || bus_mask_w !== 4'h0 || bus_data_w !== 32'h0) begin
      n_fail++; $display("FAIL abort_bus: got addr=%h mask=%h data=%h, required all 0", bus_addr, bus_mask_w, bus_data_w);
    end
    @(negedge clock);
    #2 reset = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL abort_done: got done pulse, required none"); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_missing_cycles: got %0d left, required 0", exp_q.size()); exp_q.delete(); end
    n_checks++; if (ram_rd(30'h411) !== 32'hC0DE0001) begin n_fail++; $display("FAIL abort_written: got %h, required c0de0001", ram_rd(30'h411)); end
    for (int i = 2; i < 5; i++) begin
      n_checks++;
      if (ram_rd(30'h410 + 30'(i)) !== 32'hFFFF0000 + 32'(i)) begin
        n_fail++; $display("FAIL abort_untouched[%0d]: got %h, required %h", i, ram_rd(30'h410 + 30'(i)), 32'hFFFF0000 + 32'(i));
      end
    end
    push_fill(30'h420, 2, 32'h600DF00D);
    launch(1'b1, 30'h0, 30'h420, 16'd2, 32'h600DF00D);
    wait_done(1, 20, c);
    n_checks++; if (c != 3) begin n_fail++; $display("FAIL abort_restart_done: got %0d, required 3", c); end
    @(negedge clock);
  endtask

  task automatic test_wrap;
    int c;
    push_fill(30'h3FFFFFFE, 4, 32'h0BADF00D);
    launch(1'b1, 30'h0, 30'h3FFFFFFE, 16'd4, 32'h0BADF00D);
    wait_done(1, 20, c);
    n_checks++; if (c != 5) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d, required 5", c); end
    @(negedge clock);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_missing_cycles: got %0d left, required 0", exp_q.size()); exp_q.delete(); end
    n_checks++; if (ram_rd(30'h1) !== 32'h0BADF00D) begin n_fail++; $display("FAIL wrap_ram1: got %h, required 0badf00d", ram_rd(30'h1)); end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_len_zero();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    test_wrap();
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
